// File: rtl/rsp_framer_if.sv
// Handshake/bus bundle between rsp_framer and its requesting units and byte sink.
// Latency: none, wiring only.
// Backpressure: out_ready from the sink stalls the byte stream.
interface rsp_framer_if #(
    parameter int NUNITS = 4
);
    logic [NUNITS-1:0]    invol_req;
    logic [NUNITS-1:0]    invol_grant;
    logic [32*NUNITS-1:0] param_data;
    logic [NUNITS-1:0]    param_write;
    logic [NUNITS-1:0]    unit_done;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overflow;
    logic                 timeout_err;
    logic                 busy;

    modport master (
        input  invol_req, param_data, param_write, unit_done, out_ready,
        output invol_grant, out_data, out_valid, overflow, timeout_err, busy
    );

    modport slave (
        output invol_req, param_data, param_write, unit_done, out_ready,
        input  invol_grant, out_data, out_valid, overflow, timeout_err, busy
    );
endinterface

// File: rtl/rsp_framer.sv
// Round-robin grants one unit, captures its words + response code, emits a byte frame.
// Latency: request->grant 1 cycle, done->first byte 1 cycle, then 1 byte/cycle.
// Backpressure: out_data held while out_valid && !out_ready. RSP_FRAMER_CRC_EN appends a CRC-8 trailer.
module rsp_framer #(
    parameter int NUNITS     = 4,
    parameter int MAX_PARAMS = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    rsp_framer_if.master bus
);
    localparam int PW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
    localparam int CW = $clog2(MAX_PARAMS + 1);
    localparam int WW = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_rr;
    logic [PW-1:0]     r_g;
    logic [NUNITS-1:0] r_grant;
    logic [CW-1:0]     r_cnt;
    logic [TW-1:0]     r_timer;
    logic [7:0]        r_bidx;
    logic [7:0]        r_out_data;
    logic              r_out_valid;
    logic              r_ovf;
    logic              r_to;
    logic [31:0]       r_words [MAX_PARAMS];

    logic [PW-1:0]     w_pick;
    logic              w_found;
    logic [31:0]       w_data;
    logic              w_wr;
    logic              w_done;
    logic [7:0]        w_len;
    logic [7:0]        w_last;
    logic [7:0]        w_nidx;
    logic [7:0]        w_off;
    logic [31:0]       w_word;
    logic [7:0]        w_next_byte;
    logic [PW-1:0]     w_rr_next;

    function automatic logic [PW-1:0] rr_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUNITS) s = s - NUNITS;
        return PW'(s);
    endfunction

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        for (int i = NUNITS - 1; i >= 0; i--) begin
            if (bus.invol_req[rr_add(r_rr, i)]) begin
                w_found = 1'b1;
                w_pick  = rr_add(r_rr, i);
            end
        end
    end

    assign w_data    = bus.param_data[32*r_g +: 32];
    assign w_wr      = bus.param_write[r_g];
    assign w_done    = bus.unit_done[r_g];
    assign w_rr_next = rr_add(r_g, 1);
    assign w_len     = 8'({r_cnt, 2'b00});

`ifdef RSP_FRAMER_CRC_EN
    logic [7:0] r_crc;
    logic [7:0] w_crc_nxt;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    assign w_crc_nxt = crc8_step(r_crc, r_out_data);
    assign w_last    = w_len + 8'd2;
`else
    assign w_last    = w_len + 8'd1;
`endif

    // Byte index k: 0 = code, 1 = length, 2.. = words MSB first, then optional CRC.
    always_comb begin
        w_next_byte = 8'h00;
        w_nidx      = r_bidx + 8'd1;
        w_off       = r_bidx - 8'd1;
        w_word      = r_words[WW'(w_off >> 2)];
        case (w_off[1:0])
            2'd0:    w_next_byte = w_word[31:24];
            2'd1:    w_next_byte = w_word[23:16];
            2'd2:    w_next_byte = w_word[15:8];
            default: w_next_byte = w_word[7:0];
        endcase
        if (w_nidx == 8'd1) w_next_byte = w_len;
`ifdef RSP_FRAMER_CRC_EN
        if (w_nidx == w_last) w_next_byte = w_crc_nxt;
`endif
    end

    always_ff @(posedge clk) begin
        if (r_state == COLLECT && w_wr && r_cnt != CW'(MAX_PARAMS))
            r_words[r_cnt[WW-1:0]] <= w_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr        <= '0;
            r_g         <= '0;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_bidx      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_to        <= 1'b0;
`ifdef RSP_FRAMER_CRC_EN
            r_crc       <= '0;
`endif
        end else begin
            r_grant <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_g             <= w_pick;
                        r_grant[w_pick] <= 1'b1;
                        r_timer         <= TW'(TIMEOUT);
                        r_cnt           <= '0;
                        r_state         <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_wr) begin
                        if (r_cnt == CW'(MAX_PARAMS)) r_ovf <= 1'b1;
                        else                          r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_done) begin
                        r_out_data  <= w_data[7:0];
                        r_out_valid <= 1'b1;
                        r_bidx      <= '0;
`ifdef RSP_FRAMER_CRC_EN
                        r_crc       <= '0;
`endif
                        r_state     <= EMIT;
                    end else if (r_timer == TW'(1)) begin
                        r_to    <= 1'b1;
                        r_cnt   <= '0;
                        r_rr    <= w_rr_next;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                EMIT: begin
                    if (r_out_valid && bus.out_ready) begin
`ifdef RSP_FRAMER_CRC_EN
                        r_crc <= w_crc_nxt;
`endif
                        if (r_bidx == w_last) begin
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_cnt       <= '0;
                            r_rr        <= w_rr_next;
                            r_state     <= IDLE;
                        end else begin
                            r_bidx     <= w_nidx;
                            r_out_data <= w_next_byte;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.invol_grant = r_grant;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.overflow    = r_ovf;
    assign bus.timeout_err = r_to;
    assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_rsp_framer.sv
// Randomised bench for rsp_framer against a frame-level reference model.
module tb_rsp_framer;
    localparam int NU   = 4;
    localparam int MAXP = 8;
    localparam int TMO  = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rsp_framer_if #(.NUNITS(NU)) bus ();

    rsp_framer #(.NUNITS(NU), .MAX_PARAMS(MAXP), .TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_ptr = 0;
    logic        exp_ovf = 1'b0;
    logic        exp_to = 1'b0;
    logic [31:0] wbuf [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [NU-1:0] req, input int ptr);
        for (int k = 0; k < NU; k++)
            if (req[(ptr + k) % NU]) return (ptr + k) % NU;
        return -1;
    endfunction

    // Bitwise long division of the frame, MSB first, poly x^8+x^2+x+1.
    function automatic logic [7:0] crc8(input logic [7:0] q[$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[i][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic quiet_inputs();
        bus.param_write = '0;
        bus.unit_done   = '0;
        for (int o = 0; o < NU; o++) bus.param_data[32*o +: 32] = $urandom;
    endtask

    task automatic noise(input int g);
        for (int o = 0; o < NU; o++) begin
            if (o != g) begin
                bus.param_data[32*o +: 32] = $urandom;
                bus.param_write[o]         = 1'($urandom_range(0, 1));
                bus.unit_done[o]           = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    task automatic wait_grant(output int g, output bit ok);
        int cyc;
        int g_exp;
        cyc   = 0;
        g_exp = model_pick(bus.invol_req, exp_ptr);
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.invol_grant == '0 && cyc < 20);
        check_eq("grant_latency", cyc, 1);
        check_eq("grant_onehot", 32'(bus.invol_grant), 32'd1 << g_exp);
        ok = (bus.invol_grant != '0) && (g_exp >= 0);
        g  = (g_exp < 0) ? 0 : g_exp;
        bus.invol_req[g] = 1'b0;
    endtask

    task automatic serve(input logic [7:0] code, input int n, input int mode);
        int         g;
        bit         ok;
        int         kept;
        int         got;
        int         cyc;
        int         pat;
        bit         stall;
        bit         rdy;
        logic [7:0] prev_d;
        logic [7:0] exp_q[$];
        wait_grant(g, ok);
        if (!ok) return;
        kept  = (n > MAXP) ? MAXP : n;
        exp_q = {code, 8'(kept * 4)};
        for (int i = 0; i < kept; i++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(wbuf[i][8*b +: 8]);
`ifdef RSP_FRAMER_CRC_EN
        exp_q.push_back(crc8(exp_q));
`endif
        if (n > MAXP) exp_ovf = 1'b1;
        for (int i = 0; i < n; i++) begin
            noise(g);
            bus.param_write[g]         = 1'b1;
            bus.unit_done[g]           = 1'b0;
            bus.param_data[32*g +: 32] = wbuf[i];
            @(negedge clk);
            if (i == 0) check_eq("grant_pulse", 32'(bus.invol_grant), 0);
        end
        noise(g);
        bus.param_write[g]         = 1'b0;
        bus.unit_done[g]           = 1'b1;
        bus.param_data[32*g +: 32] = {24'($urandom), code};
        @(negedge clk);
        if (n == 0) check_eq("grant_pulse", 32'(bus.invol_grant), 0);
        quiet_inputs();
        check_eq("first_valid", 32'(bus.out_valid), 1);
        got = 0; cyc = 0; pat = 0; stall = 1'b0; prev_d = 8'h00;
        while (got < exp_q.size() && cyc < 2000) begin
            if (stall) begin
                check_eq("hold_valid", 32'(bus.out_valid), 1);
                check_eq("hold_data", 32'(bus.out_data), 32'(prev_d));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (pat % 4 == 0) || (pat % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pat++;
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                check_eq("frame_byte", 32'(bus.out_data), 32'(exp_q[got]));
                got++;
            end
            stall  = bus.out_valid && !rdy;
            prev_d = bus.out_data;
            @(negedge clk);
            cyc++;
        end
        check_eq("byte_count", got, exp_q.size());
        check_eq("end_valid", 32'(bus.out_valid), 0);
        check_eq("end_busy", 32'(bus.busy), 0);
        check_eq("overflow", 32'(bus.overflow), 32'(exp_ovf));
        check_eq("timeout_err", 32'(bus.timeout_err), 32'(exp_to));
        exp_ptr = (g + 1) % NU;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bit ok;
        int cnt;
        bit saw;
        bus.invol_req = '0;
        bus.out_ready = 1'b0;
        quiet_inputs();
        repeat (3) @(negedge clk);
        check_eq("rst_grant", 32'(bus.invol_grant), 0);
        check_eq("rst_out_data", 32'(bus.out_data), 0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_overflow", 32'(bus.overflow), 0);
        check_eq("rst_timeout", 32'(bus.timeout_err), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous requesters 0,2,3 then the wrapped pointer.
        bus.invol_req = 4'b1101;
        for (int f = 0; f < 3; f++) begin
            foreach (wbuf[i]) wbuf[i] = $urandom;
            serve(8'($urandom), $urandom_range(0, 4), 0);
        end
        bus.invol_req = 4'b1001;
        foreach (wbuf[i]) wbuf[i] = $urandom;
        serve(8'h5A, 1, 0);

        // Reference frame, free-running then with a 1,0,0,1 ready pattern.
        wbuf[0] = 32'h00000001; wbuf[1] = 32'h12345678;
        wbuf[2] = 32'hCAFEBABE; wbuf[3] = 32'h00000018;
        bus.invol_req = 4'b0010;
        serve(8'h42, 4, 0);
        bus.invol_req = 4'b0010;
        serve(8'h42, 4, 1);

        // Ten words into an eight-word buffer.
        foreach (wbuf[i]) wbuf[i] = $urandom;
        bus.invol_req = 4'b0001;
        serve(8'h77, 10, 2);

        // Unit never signals done; the other requester follows.
        bus.invol_req = 4'b1100;
        wait_grant(g, ok);
        cnt = 0; saw = 1'b0;
        while (!bus.timeout_err && cnt < TMO + 50) begin
            if (bus.out_valid) saw = 1'b1;
            @(negedge clk);
            cnt++;
        end
        check_eq("timeout_cycles", cnt, TMO);
        check_eq("timeout_flag", 32'(bus.timeout_err), 1);
        check_eq("timeout_no_valid", 32'(saw), 0);
        check_eq("timeout_busy", 32'(bus.busy), 0);
        exp_to  = 1'b1;
        exp_ptr = (g + 1) % NU;
        foreach (wbuf[i]) wbuf[i] = $urandom;
        serve(8'h33, 3, 2);

        // Reset asserted while a byte is stalled.
        bus.invol_req = 4'b0010;
        wait_grant(g, ok);
        bus.param_write[g] = 1'b1;
        bus.param_data[32*g +: 32] = 32'hDEADBEEF;
        @(negedge clk);
        bus.param_write[g] = 1'b0;
        bus.unit_done[g]   = 1'b1;
        bus.param_data[32*g +: 32] = 32'h000000AA;
        bus.out_ready = 1'b0;
        @(negedge clk);
        quiet_inputs();
        repeat (2) @(negedge clk);
        check_eq("pre_reset_valid", 32'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(bus.out_valid), 0);
        check_eq("arst_out_data", 32'(bus.out_data), 0);
        check_eq("arst_busy", 32'(bus.busy), 0);
        check_eq("arst_grant", 32'(bus.invol_grant), 0);
        check_eq("arst_overflow", 32'(bus.overflow), 0);
        check_eq("arst_timeout", 32'(bus.timeout_err), 0);
        exp_ovf = 1'b0; exp_to = 1'b0; exp_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_reset_valid", 32'(bus.out_valid), 0);
        bus.invol_req = 4'b0100;
        serve(8'h01, 0, 0);

        // Random request mixes, word counts and sink behaviour.
        for (int it = 0; it < 24; it++) begin
            bus.invol_req = bus.invol_req | 4'($urandom_range(1, 15));
            foreach (wbuf[i]) wbuf[i] = $urandom;
            serve(8'($urandom), $urandom_range(0, 10), $urandom_range(0, 2));
        end
        for (int d = 0; d < NU && bus.invol_req != '0; d++) begin
            foreach (wbuf[i]) wbuf[i] = $urandom;
            serve(8'($urandom), $urandom_range(0, 6), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
